tile_fifo_writer: RTL and testbench

Parametrised FIFO-to-memory tile writer. It drains a show-ahead FIFO into memory through an Avalon-MM write master, laying the words out as a rectangular tile of runtime-selected width and height, with a programmable byte stride between rows. It replaces the fixed 16×32-word writer used by the rasteriser back end, and adds completion and abort signalling.

---
 rtl/tile_fifo_writer_pkg.sv | 18 +
 rtl/tile_fifo_writer_if.sv | 41 ++++
 rtl/tile_fifo_writer_addr_gen.sv | 70 +++++++
 rtl/tile_fifo_writer.sv | 123 ++++++++++++
 tb/tb_tile_fifo_writer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_fifo_writer_pkg.sv
// Shared types and constants for the tile FIFO writer and its address generator.
package tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

    // Per-instance word size in bytes, since a package cannot see the module's DATA_W.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/tile_fifo_writer_if.sv
// Command, status, FIFO and Avalon-MM signals of the tile writer, bundled as one interface.
interface tile_fifo_writer_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int STRIDE_W = 16,
    parameter int COL_W    = 4,
    parameter int ROW_W    = 5
);
    logic                       start;
    logic [ADDR_W-1:0]          addr_in;
    logic [STRIDE_W-1:0]        stride_in;
    logic [COL_W:0]             cols_in;
    logic [ROW_W:0]             rows_in;
    logic                       abort;
    logic                       running;
    logic                       done;
    logic                       aborted;
    logic [COL_W+ROW_W+1:0]     words_written;
    logic [DATA_W-1:0]          fifo_data;
    logic                       fifo_empty;
    logic                       fifo_ack;
    logic [ADDR_W-1:0]          master_address;
    logic                       master_write;
    logic [DATA_W-1:0]          master_writedata;
    logic [DATA_W/8-1:0]        master_byteenable;
    logic                       master_waitrequest;

    modport master (
        input  start, addr_in, stride_in, cols_in, rows_in, abort,
        input  fifo_data, fifo_empty, master_waitrequest,
        output running, done, aborted, words_written, fifo_ack,
        output master_address, master_write, master_writedata, master_byteenable
    );

    modport slave (
        output start, addr_in, stride_in, cols_in, rows_in, abort,
        output fifo_data, fifo_empty, master_waitrequest,
        input  running, done, aborted, words_written, fifo_ack,
        input  master_address, master_write, master_writedata, master_byteenable
    );
endinterface

// File: rtl/tile_fifo_writer_addr_gen.sv
// Walks a tile row by row, producing the byte address of the current word and the last-word flag.
module tile_addr_gen
    import tile_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int STRIDE_W = 16,
    parameter int COL_W    = 4,
    parameter int ROW_W    = 5,
    parameter int BPW      = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_load,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [STRIDE_W-1:0] i_stride,
    input  logic [COL_W:0]      i_cols,
    input  logic [ROW_W:0]      i_rows,
    input  logic                i_advance,
    output logic [ADDR_W-1:0]   o_cur_addr,
    output logic                o_last
);
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [STRIDE_W-1:0] r_stride;
    logic [COL_W:0]      r_cols;
    logic [ROW_W:0]      r_rows;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;

    logic                w_col_last;
    logic                w_row_last;
    logic [ADDR_W-1:0]   w_next_row;

    assign w_col_last = ({1'b0, r_col} == (r_cols - (COL_W+1)'(1)));
    assign w_row_last = ({1'b0, r_row} == (r_rows - (ROW_W+1)'(1)));
    assign w_next_row = r_row_base + ADDR_W'(r_stride);
    assign o_last     = w_col_last & w_row_last;
    assign o_cur_addr = r_cur_addr;

    // Row wrap restarts from the previous row base, not the current address, so stride is row-to-row.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row_base <= '0;
            r_cur_addr <= '0;
            r_stride   <= '0;
            r_cols     <= '0;
            r_rows     <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else if (i_load) begin
            r_row_base <= i_addr;
            r_cur_addr <= i_addr;
            r_stride   <= i_stride;
            r_cols     <= i_cols;
            r_rows     <= i_rows;
            r_col      <= '0;
            r_row      <= '0;
        end else if (i_advance) begin
            if (w_col_last) begin
                r_col      <= '0;
                r_row      <= r_row + ROW_W'(1);
                r_row_base <= w_next_row;
                r_cur_addr <= w_next_row;
            end else begin
                r_col      <= r_col + COL_W'(1);
                r_cur_addr <= r_cur_addr + ADDR_W'(BPW);
            end
        end
    end
endmodule

// File: rtl/tile_fifo_writer.sv
// Drains a show-ahead FIFO into memory as a rectangular tile through an Avalon-MM write master.
module tile_fifo_writer
    import tile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int STRIDE_W = 16,
    parameter int COL_W    = 4,
    parameter int ROW_W    = 5
) (
    input  logic               clk,
    input  logic               resetn,
    tile_fifo_writer_if.master bus
);
    localparam int BPW = bytes_per_word(DATA_W);
    localparam int WW  = COL_W + ROW_W + 2;

    state_t          r_state;
    logic            r_running;
    logic            r_done;
    logic            r_aborted;
    logic            r_abort_pend;
    logic [WW-1:0]   r_words;

    logic            w_write;
    logic            w_ack;
    logic            w_stall;
    logic            w_last;
    logic            w_empty_cmd;
    logic            w_load;
    logic [ADDR_W-1:0] w_cur_addr;

    assign w_write     = (r_state == ST_RUN) & ~bus.fifo_empty;
    assign w_ack       = w_write & ~bus.master_waitrequest;
    assign w_stall     = w_write & bus.master_waitrequest;
    assign w_empty_cmd = (bus.cols_in == '0) || (bus.rows_in == '0);
    assign w_load      = (r_state == ST_IDLE) & bus.start & ~w_empty_cmd;

    tile_addr_gen #(
        .ADDR_W   (ADDR_W),
        .STRIDE_W (STRIDE_W),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W),
        .BPW      (BPW)
    ) u_addr_gen (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_addr     (bus.addr_in),
        .i_stride   (bus.stride_in),
        .i_cols     (bus.cols_in),
        .i_rows     (bus.rows_in),
        .i_advance  (w_ack),
        .o_cur_addr (w_cur_addr),
        .o_last     (w_last)
    );

    // A final ack wins over a pending abort, so a completed tile never reports aborted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_words      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_words      <= '0;
                        r_abort_pend <= 1'b0;
                        r_aborted    <= 1'b0;
                        if (w_empty_cmd) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_ack) begin
                        r_words <= r_words + WW'(1);
                    end
                    if (w_ack && w_last) begin
                        r_state   <= ST_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b0;
                    end else if (r_abort_pend && !w_stall) begin
                        r_state   <= ST_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (bus.abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_done       <= 1'b0;
                    r_abort_pend <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.running           = r_running;
    assign bus.done              = r_done;
    assign bus.aborted           = r_aborted;
    assign bus.words_written     = r_words;
    assign bus.master_write      = w_write;
    assign bus.fifo_ack          = w_ack;
    assign bus.master_address    = w_cur_addr;
    assign bus.master_writedata  = bus.fifo_data;
    assign bus.master_byteenable = '1;
endmodule

// File: tb/tb_tile_fifo_writer.sv
// Randomised self-checking bench: a transaction-level tile model checked every cycle, plus literal pins.
module tb_tile_fifo_writer;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int STRIDE_W = 16;
    localparam int COL_W    = 4;
    localparam int ROW_W    = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tile_fifo_writer_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .COL_W(COL_W), .ROW_W(ROW_W)
    ) bus ();

    tile_fifo_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int nCompared = 0;
    int nMismatched = 0;
    int cycleNo = 0;
    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Environment knobs read by the FIFO/slave driver
    int stallPct = 0;
    int emptyPct = 0;
    bit forceFull = 0;
    bit forceStall = 0;
    bit popped = 0;
    bit stalledWrite = 0;
    logic [31:0] prevFifoData = '0;

    // Tile model: the k-th accepted word of a tile lands at base + (k / cols) * stride + (k % cols) * 4
    bit          mRunning = 0;
    bit          mDone = 0;
    bit          mAborted = 0;
    bit          mPend = 0;
    int          mWords = 0;
    int          mIdx = 0;
    int          mTotal = 0;
    int          mCols = 1;
    logic [31:0] mAddr = '0;
    logic [31:0] mStride = '0;

    logic [31:0] ackLog[$];
    int startCycle = 0;
    int firstWriteCycle = -1;
    int doneCycle = 0;
    int writesSeen = 0;
    logic doneAborted;
    logic [COL_W+ROW_W+1:0] doneWords;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    function automatic logic [31:0] addrOf(input int idx);
        logic [31:0] row;
        logic [31:0] col;
        row = 32'(idx / mCols);
        col = 32'(idx % mCols);
        return mAddr + row * mStride + col * 32'd4;
    endfunction

    // FIFO and Avalon slave behaviour; a stalled write keeps its head word present
    initial begin
        bus.fifo_data = $urandom;
        bus.fifo_empty = 1'b1;
        bus.master_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (popped) bus.fifo_data = $urandom;
            bus.master_waitrequest = forceStall ? 1'b1 : ($urandom_range(0, 99) < stallPct);
            if (stalledWrite) bus.fifo_empty = 1'b0;
            else bus.fifo_empty = forceFull ? 1'b0 : ($urandom_range(0, 99) < emptyPct);
        end
    end

    // Per-cycle compare against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        bit expWrite;
        bit expAck;
        if (!resetn) begin
            checkOutput("rst_running", 64'(bus.running), 64'd0);
            checkOutput("rst_done", 64'(bus.done), 64'd0);
            checkOutput("rst_write", 64'(bus.master_write), 64'd0);
            checkOutput("rst_ack", 64'(bus.fifo_ack), 64'd0);
            checkOutput("rst_words", 64'(bus.words_written), 64'd0);
            checkOutput("rst_address", 64'(bus.master_address), 64'd0);
            mRunning = 0; mDone = 0; mAborted = 0; mPend = 0; mWords = 0; mIdx = 0;
            popped = 0; stalledWrite = 0;
        end else begin
            expWrite = mRunning && !bus.fifo_empty;
            expAck = expWrite && !bus.master_waitrequest;
            checkOutput("running", 64'(bus.running), 64'(mRunning));
            checkOutput("done", 64'(bus.done), 64'(mDone));
            if (mDone) checkOutput("aborted", 64'(bus.aborted), 64'(mAborted));
            checkOutput("words_written", 64'(bus.words_written), 64'(mWords));
            checkOutput("master_write", 64'(bus.master_write), 64'(expWrite));
            checkOutput("fifo_ack", 64'(bus.fifo_ack), 64'(expAck));
            if (expWrite) begin
                checkOutput("address", 64'(bus.master_address), 64'(addrOf(mIdx)));
                checkOutput("writedata", 64'(bus.master_writedata), 64'(bus.fifo_data));
                checkOutput("byteenable", 64'(bus.master_byteenable), 64'hF);
                if (stalledWrite) checkOutput("stall_data", 64'(bus.master_writedata), 64'(prevFifoData));
                if (firstWriteCycle < 0) firstWriteCycle = cycleNo;
            end
            if (bus.master_write) writesSeen++;

            popped = expAck;
            stalledWrite = expWrite && bus.master_waitrequest;
            prevFifoData = bus.fifo_data;

            if (mDone) begin
                mDone = 0;
            end else if (!mRunning) begin
                if (bus.start) begin
                    mWords = 0; mAborted = 0; mPend = 0;
                    if (bus.cols_in == 0 || bus.rows_in == 0) begin
                        mDone = 1;
                    end else begin
                        mRunning = 1;
                        mIdx = 0;
                        mCols = int'(bus.cols_in);
                        mTotal = int'(bus.cols_in) * int'(bus.rows_in);
                        mAddr = bus.addr_in;
                        mStride = 32'(bus.stride_in);
                    end
                end
            end else begin
                if (expAck) begin
                    ackLog.push_back(bus.master_address);
                    mIdx++;
                    mWords++;
                end
                if (expAck && mIdx == mTotal) begin
                    mRunning = 0; mDone = 1; mAborted = 0;
                end else if (mPend && !stalledWrite) begin
                    mRunning = 0; mDone = 1; mAborted = 1;
                end else if (bus.abort) begin
                    mPend = 1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] stride,
                                 input int cols, input int rows);
        @(posedge clk);
        #2;
        bus.addr_in = addr;
        bus.stride_in = stride;
        bus.cols_in = (COL_W+1)'(cols);
        bus.rows_in = (ROW_W+1)'(rows);
        bus.start = 1'b1;
        startCycle = cycleNo;
        firstWriteCycle = -1;
        writesSeen = 0;
        ackLog.delete();
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit randomAbort);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1;
                doneCycle = cycleNo;
                doneAborted = bus.aborted;
                doneWords = bus.words_written;
                break;
            end
            if (randomAbort) begin
                @(posedge clk);
                #2;
                bus.abort = ($urandom_range(0, 99) < 4);
            end
        end
        bus.abort = 1'b0;
        if (!ok) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        logic [31:0] wrapExp [6];
        wrapExp[0] = 32'hFFFF_FFF8; wrapExp[1] = 32'hFFFF_FFFC; wrapExp[2] = 32'h0000_0000;
        wrapExp[3] = 32'h0000_0000; wrapExp[4] = 32'h0000_0004; wrapExp[5] = 32'h0000_0008;

        bus.start = 1'b0; bus.abort = 1'b0;
        bus.addr_in = '0; bus.stride_in = '0; bus.cols_in = '0; bus.rows_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_running", 64'(bus.running), 64'd0);
        checkOutput("reset_aborted", 64'(bus.aborted), 64'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;

        $display("[TB] basic 16x32 tile");
        forceFull = 1; stallPct = 0; emptyPct = 0;
        applyStimulus(32'h1000, 16'h400, 16, 32);
        waitDone(2000, 0);
        checkOutput("basic_acks", 64'(ackLog.size()), 64'd512);
        if (ackLog.size() == 512) begin
            checkOutput("basic_addr1", 64'(ackLog[1]), 64'h1004);
            checkOutput("basic_addr16", 64'(ackLog[16]), 64'h1400);
            checkOutput("basic_last_addr", 64'(ackLog[511]), 64'h8C3C);
        end
        checkOutput("basic_first_write", 64'(firstWriteCycle - startCycle), 64'd1);
        checkOutput("basic_done_latency", 64'(doneCycle - startCycle), 64'd513);
        checkOutput("basic_words", 64'(doneWords), 64'd512);
        checkOutput("basic_aborted", 64'(doneAborted), 64'd0);

        $display("[TB] address wrap 3x2");
        applyStimulus(32'hFFFF_FFF8, 16'h8, 3, 2);
        waitDone(100, 0);
        checkOutput("wrap_acks", 64'(ackLog.size()), 64'd6);
        if (ackLog.size() == 6)
            for (int i = 0; i < 6; i++) checkOutput($sformatf("wrap_addr%0d", i), 64'(ackLog[i]), 64'(wrapExp[i]));

        $display("[TB] empty tiles");
        applyStimulus(32'h5000, 16'h10, 0, 5);
        waitDone(20, 0);
        checkOutput("empty_cols_latency", 64'(doneCycle - startCycle), 64'd1);
        checkOutput("empty_cols_writes", 64'(writesSeen), 64'd0);
        checkOutput("empty_cols_aborted", 64'(doneAborted), 64'd0);
        applyStimulus(32'h5000, 16'h10, 3, 0);
        waitDone(20, 0);
        checkOutput("empty_rows_latency", 64'(doneCycle - startCycle), 64'd1);
        checkOutput("empty_rows_writes", 64'(writesSeen), 64'd0);

        $display("[TB] stall and empty 4x2");
        forceFull = 0; stallPct = 40; emptyPct = 30;
        applyStimulus(32'h2000, 16'h100, 4, 2);
        waitDone(500, 0);
        checkOutput("stall_acks", 64'(ackLog.size()), 64'd8);
        checkOutput("stall_words", 64'(doneWords), 64'd8);

        $display("[TB] abort during stall");
        forceFull = 1; stallPct = 0; emptyPct = 0; forceStall = 1;
        applyStimulus(32'h3000, 16'h100, 4, 4);
        bus.abort = 1'b1;
        @(posedge clk);
        #2;
        bus.abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        forceStall = 0;
        waitDone(50, 0);
        checkOutput("abort_aborted", 64'(doneAborted), 64'd1);
        checkOutput("abort_words", 64'(doneWords), 64'd1);
        checkOutput("abort_acks", 64'(ackLog.size()), 64'd1);

        $display("[TB] start during run");
        applyStimulus(32'h6000, 16'h40, 2, 3);
        bus.addr_in = 32'h7000; bus.cols_in = 5'd5; bus.rows_in = 6'd5; bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        waitDone(100, 0);
        checkOutput("restart_words", 64'(doneWords), 64'd6);
        if (ackLog.size() == 6) checkOutput("restart_last_addr", 64'(ackLog[5]), 64'h6084);

        $display("[TB] reset mid-tile");
        applyStimulus(32'h8000, 16'h20, 4, 4);
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_write", 64'(bus.master_write), 64'd0);
        checkOutput("midrst_running", 64'(bus.running), 64'd0);
        checkOutput("midrst_words", 64'(bus.words_written), 64'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        applyStimulus(32'h4000, 16'h10, 3, 1);
        waitDone(100, 0);
        checkOutput("fresh_words", 64'(doneWords), 64'd3);
        if (ackLog.size() == 3) begin
            checkOutput("fresh_addr0", 64'(ackLog[0]), 64'h4000);
            checkOutput("fresh_addr2", 64'(ackLog[2]), 64'h4008);
        end

        $display("[TB] randomised commands");
        forceFull = 0;
        for (int n = 0; n < 8; n++) begin
            stallPct = $urandom_range(0, 50);
            emptyPct = $urandom_range(0, 50);
            applyStimulus($urandom, 16'($urandom), $urandom_range(0, 16), $urandom_range(0, 6));
            waitDone(1500, 1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
